// File: rtl/i2c_pkg.sv
// Shared I2C block constants: byte width and FIFO geometry used by the
// controller, the FIFOs and the top level.
package i2c_pkg;

    localparam int I2C_DATA_WIDTH      = 8;
    localparam int I2C_FIFO_ADDR_WIDTH = 4;
    localparam int I2C_FIFO_AF_LVL     = 12;

endpackage

// File: rtl/i2c_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset,
// so a vendor RAM with an output bypass can drop in here.
module i2c_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_fifo.sv
// Show-ahead byte FIFO between the host and the I2C master controller.
// Pointers carry an extra wrap bit so full/empty/usedw fall out of them directly.
module i2c_fifo
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH      = I2C_DATA_WIDTH,
    parameter int ADDR_WIDTH      = I2C_FIFO_ADDR_WIDTH,
    parameter int ALMOST_FULL_LVL = I2C_FIFO_AF_LVL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  overflow,
    output logic                  underflow
);

    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  wr_en, rd_en;

    assign usedw       = wr_ptr - rd_ptr;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                         (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign almost_full = (int'(usedw) >= ALMOST_FULL_LVL);
    assign data_out    = empty ? '0 : ram_q;

    // A write into a full FIFO is accepted only when a pop frees the slot this edge.
    assign wr_en = write & (~full | read) & ~clear;
    assign rd_en = read & ~empty & ~clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (write & ~wr_en)
                overflow <= 1'b1;
            if (read & empty)
                underflow <= 1'b1;
        end
    end

    i2c_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr[ADDR_WIDTH-1:0]),
        .wdata(data_in),
        .raddr(rd_ptr[ADDR_WIDTH-1:0]),
        .rdata(ram_q)
    );

endmodule

// File: tb/tb_i2c_fifo.sv
// Bench for i2c_fifo: directed vector table, hand-written corner sequences and
// random traffic checked against a queue-based model of the FIFO rules.
module tb_i2c_fifo;

    logic       clk = 1'b0;
    logic       reset, clear, write, read;
    logic [7:0] data_in, data_out;
    logic       empty, full, almost_full, overflow, underflow;
    logic [4:0] usedw;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    byte unsigned q[$];
    bit           m_ovf, m_unf;

    always #10 clk = ~clk;

    i2c_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .write      (write),
        .data_in    (data_in),
        .read       (read),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .usedw      (usedw),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    typedef struct {
        bit       wr;
        bit [7:0] din;
        bit       rd;
        bit       clr;
        bit [7:0] e_dout;
        int       e_used;
        bit       e_empty;
        bit       e_full;
        bit       e_ovf;
        bit       e_unf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
    endfunction

    function automatic void model_step(input bit wr, input bit [7:0] din, input bit rd, input bit clr);
        bit was_full, was_empty;
        if (clr) begin
            model_reset();
            return;
        end
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        if (rd && was_empty)            m_unf = 1;
        if (wr && was_full && !rd)      m_ovf = 1;
        if (rd && !was_empty)           void'(q.pop_front());
        if (wr && (!was_full || rd))    q.push_back(din);
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, ".data_out"},    data_out,    (q.size() != 0) ? q[0] : 8'h00);
        chk({tag, ".usedw"},       usedw,       q.size());
        chk({tag, ".empty"},       empty,       q.size() == 0);
        chk({tag, ".full"},        full,        q.size() == 16);
        chk({tag, ".almost_full"}, almost_full, q.size() >= 12);
        chk({tag, ".overflow"},    overflow,    m_ovf);
        chk({tag, ".underflow"},   underflow,   m_unf);
    endtask

    // Drive one cycle of inputs, let the edge pass, sample 1 time unit later.
    task automatic step(input bit wr, input bit [7:0] din, input bit rd, input bit clr);
        write   = wr;
        data_in = din;
        read    = rd;
        clear   = clr;
        @(posedge clk);
        #1;
        model_step(wr, din, rd, clr);
        write = 0; read = 0; clear = 0;
    endtask

    vec_t vt[$];

    initial begin
        reset = 1; clear = 0; write = 0; read = 0; data_in = 0;
        model_reset();

        vt.push_back('{0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0});
        vt.push_back('{1, 8'hA5, 0, 0, 8'hA5, 1, 0, 0, 0, 0});
        vt.push_back('{0, 8'h00, 0, 0, 8'hA5, 1, 0, 0, 0, 0});
        vt.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 0, 0});
        vt.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 0, 1});
        vt.push_back('{1, 8'h33, 1, 0, 8'h33, 1, 0, 0, 0, 1});
        vt.push_back('{1, 8'h44, 0, 0, 8'h33, 2, 0, 0, 0, 1});
        vt.push_back('{1, 8'h77, 0, 1, 8'h00, 0, 1, 0, 0, 0});
        vt.push_back('{0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0});

        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk_model("reset");

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].wr, vt[i].din, vt[i].rd, vt[i].clr);
            chk($sformatf("vec%0d.data_out", i),  data_out,  vt[i].e_dout);
            chk($sformatf("vec%0d.usedw", i),     usedw,     vt[i].e_used);
            chk($sformatf("vec%0d.empty", i),     empty,     vt[i].e_empty);
            chk($sformatf("vec%0d.full", i),      full,      vt[i].e_full);
            chk($sformatf("vec%0d.overflow", i),  overflow,  vt[i].e_ovf);
            chk($sformatf("vec%0d.underflow", i), underflow, vt[i].e_unf);
        end

        // Fill, overflow, and cross the address wrap.
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0);
            chk_model($sformatf("fill%0d", i));
        end
        chk("fill.full", full, 1'b1);
        step(1, 8'hFF, 0, 0);
        chk("ovf.flag", overflow, 1'b1);
        chk("ovf.usedw", usedw, 5'd16);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pop8.word%0d", i), data_out, 8'(i));
            step(0, 0, 1, 0);
        end
        for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0, 0);
        chk_model("wrap");
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain.word%0d", i), data_out, 8'(8'h08 + i));
            step(0, 0, 1, 0);
        end
        chk_model("drained");

        // Full with simultaneous read and write.
        step(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 8'(8'hC0 + i), 0, 0);
        step(1, 8'h55, 1, 0);
        chk("fullrw.usedw", usedw, 5'd16);
        chk("fullrw.full", full, 1'b1);
        chk("fullrw.ovf", overflow, 1'b0);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 0);
        chk("fullrw.last", data_out, 8'h55);
        step(0, 0, 1, 0);
        chk_model("fullrw.end");

        // Clear with a pending write and sticky flags set.
        step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0);
        step(1, 8'h77, 0, 1);
        chk_model("clear");
        chk("clear.no77", data_out, 8'h00);

        // Async reset between edges with 9 words stored.
        for (int i = 0; i < 9; i++) step(1, 8'(8'h90 + i), 0, 0);
        chk("prereset.usedw", usedw, 5'd9);
        #3 reset = 1;
        #1;
        model_reset();
        chk("areset.empty", empty, 1'b1);
        chk("areset.usedw", usedw, 5'd0);
        chk("areset.dout", data_out, 8'h00);
        @(posedge clk);
        #1 reset = 0;
        step(1, 8'hB7, 0, 0);
        chk_model("postreset.push");
        step(0, 0, 1, 0);
        chk_model("postreset.pop");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit wr, rd, clr;
            wr  = ($urandom_range(99) < 55);
            rd  = ($urandom_range(99) < 45);
            clr = ($urandom_range(99) < 2);
            step(wr, 8'($urandom), rd, clr);
            chk_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
